// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game core and its button front end.
// Latency: none (declarations only).
// Backpressure: none.
package simon_pkg;

    localparam int NUM_BTNS            = 4;
    localparam int DEFAULT_DEBOUNCE_MS = 10;

    typedef logic [NUM_BTNS-1:0] btn_vec_t;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_e;

    // Keeps only the lowest set bit of v, so simultaneous presses resolve to one winner.
    function automatic btn_vec_t lowest_set(input btn_vec_t v);
        btn_vec_t r;
        r = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_buttons_if.sv
// Button-conditioner bus: raw pins and time base in, clean levels and events out.
// Latency: none (wiring only).
// Backpressure: none; every signal is a plain level or a 1-cycle pulse.
interface simon_buttons_if
    import simon_pkg::*;
#(
    parameter int TPM_W = 16
);
    logic [TPM_W-1:0] ticks_per_milli;
    btn_vec_t         btn_raw;
    btn_vec_t         btn;
    btn_vec_t         btn_press;
    btn_vec_t         btn_release;
    logic             btn_any;

    modport master (
        output ticks_per_milli, btn_raw,
        input  btn, btn_press, btn_release, btn_any
    );

    modport slave (
        input  ticks_per_milli, btn_raw,
        output btn, btn_press, btn_release, btn_any
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: 2-FF synchroniser, millisecond-tick debounce counter and accepted level.
// Latency: 2 sync cycles + (DEBOUNCE_MS-1)*T+1..DEBOUNCE_MS*T cycles + 1 register cycle.
// Backpressure: none; level_d_o exposes the next level so the parent can register events alongside it.
module debounce_channel
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic ms_tick_i,
    output logic level_o,
    output logic level_d_o
);
    localparam int             CNT_W    = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_MS);

    logic [1:0]       sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             mismatch;

    // Synchroniser, FSM state, tick counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Count ticks while the synchronised pin disagrees with the level; accept once DEBOUNCE_MS ticks have passed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        mismatch = sync_q[1] ^ level_q;
        unique case (state_q)
            ST_STABLE: begin
                if (mismatch) begin
                    // The tick of the first mismatched cycle already counts.
                    state_d = ST_CHANGING;
                    cnt_d   = ms_tick_i ? CNT_W'(1) : '0;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHANGING: begin
                if (!mismatch) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = sync_q[1];
                end else if (ms_tick_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

endmodule

// File: rtl/simon_buttons.sv
// Simon push-button conditioner: shared ms prescaler, four debounce channels, press arbitration.
// Latency: btn, events and btn_any all update on the same edge, 1 cycle after a channel accepts.
// Backpressure: none; events are single-cycle pulses with no hold-off.
module simon_buttons
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
    parameter int TPM_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    simon_buttons_if.slave bus
);
    logic [TPM_W-1:0] presc_q, presc_d, presc_last;
    logic             ms_tick;
    logic             tpm_small;

    btn_vec_t btn_q, btn_d;
    btn_vec_t rise;
    btn_vec_t press_q, press_d;
    btn_vec_t release_q, release_d;
    logic     any_q, any_d;

    // Prescaler next count: wraps on the terminal count, or silently if the period shrank below it.
    always_comb begin
        tpm_small  = (bus.ticks_per_milli <= TPM_W'(1));
        presc_last = bus.ticks_per_milli - TPM_W'(1);
        ms_tick    = tpm_small || (presc_q == presc_last);
        if (tpm_small || (presc_q >= presc_last)) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (bus.btn_raw[g]),
            .ms_tick_i(ms_tick),
            .level_o  (btn_q[g]),
            .level_d_o(btn_d[g])
        );
    end

    // A press only counts when no button was already down; ties go to the lowest index.
    always_comb begin
        rise      = btn_d & ~btn_q;
        press_d   = (btn_q == '0) ? lowest_set(rise) : '0;
        release_d = btn_q & ~btn_d;
        any_d     = |btn_d;
    end

    // Prescaler and event registers, aligned with the channel level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    assign bus.btn         = btn_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_any     = any_q;

endmodule

// File: tb/tb_simon_buttons.sv
// Bench for simon_buttons: cycle-by-cycle comparison against a behavioural model plus directed latency checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_simon_buttons;
    import simon_pkg::*;

    localparam int D = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simon_buttons_if #(.TPM_W(16)) bus ();

    simon_buttons #(.DEBOUNCE_MS(D), .TPM_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Behavioural model: pins pass a 2-deep delay, a button flips once it has
    // disagreed with its level across D ms ticks and is still disagreeing.
    int       pc;
    bit [3:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    bit       m_any;
    int       m_seen [4];

    always @(posedge clk) begin : model
        int       tpm;
        int       tick;
        bit [3:0] nl;
        tpm = int'(bus.ticks_per_milli);
        if (rst) begin
            pc = 0; m_s1 = '0; m_s2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0; m_any = 1'b0;
            for (int i = 0; i < 4; i++) m_seen[i] = 0;
        end else begin
            tick = ((tpm <= 1) || (pc == tpm - 1)) ? 1 : 0;
            pc   = ((tpm <= 1) || (pc >= tpm - 1)) ? 0 : pc + 1;
            nl   = m_lvl;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    if (m_seen[i] >= D) begin
                        nl[i]     = m_s2[i];
                        m_seen[i] = 0;
                    end else begin
                        m_seen[i] += tick;
                    end
                end else begin
                    m_seen[i] = 0;
                end
            end
            m_rel   = m_lvl & ~nl;
            m_press = '0;
            if (m_lvl == 4'b0000) begin
                for (int i = 0; i < 4; i++)
                    if (nl[i] && m_press == 4'b0000) m_press[i] = 1'b1;
            end
            m_any = |nl;
            m_lvl = nl;
            m_s2  = m_s1;
            m_s1  = bus.btn_raw;
        end
    end

    int       press_cnt [4];
    int       rel_cnt   [4];
    bit [3:0] last_press;

    // Compare every cycle, away from the active edge, and tally events for the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("btn",         bus.btn,         m_lvl);
            chk("btn_press",   bus.btn_press,   m_press);
            chk("btn_release", bus.btn_release, m_rel);
            chk("btn_any",     bus.btn_any,     m_any);
            chk("press_onehot0", $onehot0(bus.btn_press), 1);
            chk("press_rel_overlap", bus.btn_press & bus.btn_release, 0);
            for (int i = 0; i < 4; i++) begin
                if (bus.btn_press[i] === 1'b1)   press_cnt[i]++;
                if (bus.btn_release[i] === 1'b1) rel_cnt[i]++;
            end
            if (bus.btn_press != 4'b0000) last_press = bus.btn_press;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_ev();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
        last_press = '0;
    endtask

    // Edges counted from the drive until btn equals exp; -1 if the budget runs out.
    task automatic wait_btn(input bit [3:0] exp, input int maxc, output int lat);
        lat = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(posedge clk);
            #1;
            if (bus.btn === exp) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic int sum_press();
        return press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
    endfunction

    initial begin
        int lat;
        rst                 = 1'b1;
        bus.btn_raw         = 4'b1111;
        bus.ticks_per_milli = 16'd4;
        clr_ev();
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset with all buttons held, then accepted together after release.
        tick_n(5);
        chk("rst_btn", bus.btn, 4'b0000);
        chk("rst_any", bus.btn_any, 0);
        clr_ev();
        rst = 1'b0;
        wait_btn(4'b1111, 25, lat);
        chk_rng("rst_accept_latency", lat, 11, 15);
        tick_n(2);
        chk("rst_press0", press_cnt[0], 1);
        chk("rst_press_total", sum_press(), 1);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // Clean press and release of button 2.
        clr_ev();
        bus.btn_raw = 4'b0100;
        wait_btn(4'b0100, 25, lat);
        chk_rng("press2_latency", lat, 11, 15);
        tick_n(2);
        chk("press2_vec", last_press, 4'b0100);
        chk("press2_total", sum_press(), 1);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        chk_rng("release2_latency", lat, 11, 15);
        tick_n(2);
        chk("release2_cnt", rel_cnt[2], 1);
        tick_n(3);

        // Bounce on button 1: 5-cycle glitches stay invisible.
        clr_ev();
        for (int k = 0; k < 12; k++) begin
            bus.btn_raw[1] = ~bus.btn_raw[1];
            tick_n(5);
        end
        tick_n(4);
        chk("bounce_no_press", sum_press(), 0);
        chk("bounce_btn", bus.btn, 4'b0000);
        bus.btn_raw = 4'b0010;
        tick_n(20);
        chk("bounce_settled_press1", press_cnt[1], 1);
        chk("bounce_settled_total", sum_press(), 1);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // Simultaneous press of 1 and 3, then 0 added while 1 is held.
        clr_ev();
        bus.btn_raw = 4'b1010;
        wait_btn(4'b1010, 25, lat);
        chk_rng("simul_latency", lat, 11, 15);
        tick_n(2);
        chk("simul_press_vec", last_press, 4'b0010);
        chk("simul_press_total", sum_press(), 1);
        bus.btn_raw = 4'b1011;
        wait_btn(4'b1011, 25, lat);
        chk_rng("held_press0_latency", lat, 11, 15);
        tick_n(2);
        chk("held_no_press0", press_cnt[0], 0);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // ticks_per_milli = 0: one tick per cycle.
        bus.ticks_per_milli = 16'd0;
        tick_n(2);
        bus.btn_raw = 4'b1000;
        wait_btn(4'b1000, 25, lat);
        chk("tpm0_latency", lat, 6);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // Period lowered from 50 to 4 while the prescaler sits at 30.
        bus.ticks_per_milli = 16'd50;
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        tick_n(30);
        bus.ticks_per_milli = 16'd4;
        bus.btn_raw         = 4'b0100;
        wait_btn(4'b0100, 25, lat);
        chk("tpm_shrink_latency", lat, 14);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // Reset in the middle of debouncing button 3.
        clr_ev();
        bus.btn_raw = 4'b1000;
        tick_n(6);
        rst = 1'b1;
        tick_n(2);
        chk("mid_rst_btn", bus.btn, 4'b0000);
        chk("mid_rst_no_press", press_cnt[3], 0);
        rst = 1'b0;
        wait_btn(4'b1000, 25, lat);
        chk("mid_rst_latency", lat, 13);
        tick_n(2);
        chk("mid_rst_press3", press_cnt[3], 1);
        bus.btn_raw = 4'b0000;
        wait_btn(4'b0000, 25, lat);
        tick_n(3);

        // Randomised pins, periods and resets, checked by the model every cycle.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 9) == 0)
                bus.ticks_per_milli = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                tick_n(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0)
                bus.btn_raw = bus.btn_raw ^ 4'($urandom_range(0, 15));
            else
                bus.btn_raw[$urandom_range(0, 3)] = ~bus.btn_raw[$urandom_range(0, 3)];
            tick_n($urandom_range(1, 25));
        end
        tick_n(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
